emif_bus_io: RTL

- Parametrised EMIF data-bus I/O controller in the clk_400M domain. It replaces the single 16-bit register/tri-state driver in the top-level.
- Provides burst read-out to the MCU with programmable CAS latency, beat length, hold and bus-turnaround guard. Also captures MCU write data, with collision detection.
- The pad tri-state stays at top level: emif_data = bus_oe ? bus_out : 'z; bus_in = emif_data.

---
 rtl/emif_bus_io.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/emif_bus_io.sv
// EMIF data-bus I/O controller: CAS-latency burst read-out with hold/turnaround guard,
// MCU write capture and sticky collision flag. Define EMIF_BUS_IO_BYTE_MASK_EN for dqm byte masking.
module emif_bus_io #(
    parameter int DATA_W    = 16,
    parameter int CAS_LAT   = 2,
    parameter int DRV_CYC   = 4,
    parameter int BURST_MAX = 8,
    parameter int TURN_CYC  = 2
) (
    input  logic                clk_400M,
    input  logic                rst_n,
    input  logic                rd_req,
    input  logic [3:0]          burst_len,
    input  logic [DATA_W-1:0]   rd_data,
    output logic                rd_pop,
    input  logic                abort,
    input  logic [DATA_W-1:0]   bus_in,
    output logic [DATA_W-1:0]   bus_out,
    output logic                bus_oe,
    input  logic                wr_strobe,
    input  logic [DATA_W/8-1:0] dqm,
    output logic [DATA_W-1:0]   cap_data,
    output logic                cap_valid,
    output logic                busy,
    output logic                err_collision,
    input  logic                err_clr
);
    localparam int CMAX = (CAS_LAT > DRV_CYC) ? ((CAS_LAT > TURN_CYC) ? CAS_LAT : TURN_CYC)
                                              : ((DRV_CYC > TURN_CYC) ? DRV_CYC : TURN_CYC);
    localparam int CNT_W  = $clog2(CMAX + 1);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(CAS_LAT - 1);
    localparam logic [CNT_W-1:0] DRV_LAST  = CNT_W'(DRV_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAT, DRIVE, HOLD, TURN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [3:0]          len_eff;
    logic                load;
    logic                rd_pop_q, rd_pop_d;
    logic [DATA_W-1:0]   bus_out_q, bus_out_d;
    logic                bus_oe_q, bus_oe_d;
    logic [DATA_W-1:0]   cap_data_q, cap_data_d;
    logic                cap_valid_q, cap_valid_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    always_comb begin
        len_eff = burst_len;
        if (burst_len == 4'd0)
            len_eff = 4'd1;
        else if (int'(burst_len) > BURST_MAX)
            len_eff = 4'(BURST_MAX);
    end

    // beat_q holds the beats still to come after the current one
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        load    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = LAT;
                    cnt_d   = '0;
                    beat_d  = BEAT_W'(len_eff - 4'd1);
                end
            end
            LAT: begin
                if (abort) begin
                    state_d = TURN;
                    cnt_d   = '0;
                    beat_d  = '0;
                end else if (cnt_q == LAT_LAST) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = TURN;
                    cnt_d   = '0;
                    beat_d  = '0;
                end else if (cnt_q == DRV_LAST) begin
                    cnt_d = '0;
                    if (beat_q != '0) begin
                        beat_d = beat_q - 1'b1;
                        load   = 1'b1;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                state_d = TURN;
                cnt_d   = '0;
                beat_d  = '0;
            end
            TURN: begin
                if (cnt_q == TURN_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                beat_d  = '0;
            end
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it
    always_comb begin
        rd_pop_d    = ((state_d == LAT) && (cnt_d == LAT_LAST)) ||
                      ((state_d == DRIVE) && (cnt_d == DRV_LAST) && (beat_d != '0));
        bus_oe_d    = (state_d == DRIVE) || (state_d == HOLD);
        bus_out_d   = load ? rd_data : bus_out_q;
        busy_d      = (state_d != IDLE);
        cap_data_d  = cap_data_q;
        cap_valid_d = 1'b0;
        err_d       = err_q;
        if ((state_q == IDLE) && !bus_oe_q && wr_strobe) begin
            cap_valid_d = 1'b1;
`ifdef EMIF_BUS_IO_BYTE_MASK_EN
            for (int unsigned i = 0; i < NBYTES; i++)
                if (!dqm[i])
                    cap_data_d[i*8 +: 8] = bus_in[i*8 +: 8];
`else
            cap_data_d = bus_in;
`endif
        end
        if ((state_q != IDLE) && wr_strobe)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

`ifndef EMIF_BUS_IO_BYTE_MASK_EN
    logic dqm_unused;
    assign dqm_unused = ^dqm;
`endif

    always_ff @(posedge clk_400M or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            rd_pop_q    <= 1'b0;
            bus_out_q   <= '0;
            bus_oe_q    <= 1'b0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            beat_q      <= beat_d;
            rd_pop_q    <= rd_pop_d;
            bus_out_q   <= bus_out_d;
            bus_oe_q    <= bus_oe_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign rd_pop        = rd_pop_q;
    assign bus_out       = bus_out_q;
    assign bus_oe        = bus_oe_q;
    assign cap_data      = cap_data_q;
    assign cap_valid     = cap_valid_q;
    assign busy          = busy_q;
    assign err_collision = err_q;

endmodule
